// File: rtl/d16i_irq_pkg.sv
// Shared types and helpers for the D16i interrupt controller.
package d16i_irq_pkg;

  localparam int IRQ_ID_W    = 16;
  localparam int IRQ_BUS_W   = 17;
  localparam int IRQ_MAX_SRC = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    LOAD    = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // Lowest set index wins; valid is low when the vector is empty.
  function automatic prio_t prio_enc(input logic [IRQ_MAX_SRC-1:0] vec);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one external interrupt line, plus a history
// flop so a single-cycle rise pulse can be produced in the clk domain.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Metastability chain followed by the previous-value flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the D16i core: synchronises and edge-detects the
// external lines, latches pending/overflow bits, arbitrates by fixed priority
// at ack time and strobes the winning ID into the regfile IRQ write port.
module irq_ctrl
  import d16i_irq_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [15:0] ID_BASE    = 16'h0010,
  parameter logic [15:0] MASK_RESET = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     irq_lines,
  input  logic                 mask_we,
  input  logic [15:0]          mask_wdata,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 irq_req,
  output logic                 irq_sel,
  output logic [IRQ_BUS_W-1:0] irq_bus,
  output logic                 irq_active,
  output logic [N_SRC-1:0]     pending
);

  irq_state_t state;
  irq_state_t state_next;

  logic [N_SRC-1:0]       rise;
  logic [N_SRC-1:0]       overflow;
  logic [N_SRC-1:0]       clr;
  logic [IRQ_ID_W-1:0]    mask;
  logic [IRQ_ID_W-1:0]    mask_next;
  logic [IRQ_MAX_SRC-1:0] pend_ext;
  logic                   fire;
  logic                   win_ovf;
  prio_t                  win;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .line (irq_lines[g]),
      .rise (rise[g])
    );
  end

  // Arbitration in REQ looks at the mask being written this cycle, so a mask
  // write that coincides with irq_ack can withdraw the request before LOAD.
  always_comb begin
    mask_next = mask_we ? mask_wdata : mask;
    pend_ext  = '0;
    pend_ext[N_SRC-1:0] = pending;
    win = prio_enc(pend_ext & mask_next);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; fire marks the acceptance edge (REQ -> LOAD).
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (|(pend_ext & mask)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!win.valid) begin
          state_next = IDLE;
        end else if (irq_ack) begin
          state_next = LOAD;
          fire       = 1'b1;
        end
      end
      LOAD: begin
        state_next = SERVICE;
      end
      SERVICE: begin
        if (irq_eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot clear of the winner and its overflow flag captured for irq_bus.
  always_comb begin
    clr     = '0;
    win_ovf = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i]  = fire && (win.idx == 4'(i));
      win_ovf = win_ovf | (overflow[i] && (win.idx == 4'(i)));
    end
  end

  // Pending/overflow/mask; a rise wins over a same-cycle clear and then
  // does not count as an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
      mask     <= MASK_RESET;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= (overflow & ~clr) | (rise & pending & ~clr);
      mask     <= mask_next;
    end
  end

  // Registered outputs decoded from the next state so they change cleanly on posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_req    <= 1'b0;
      irq_sel    <= 1'b0;
      irq_active <= 1'b0;
      irq_bus    <= '0;
    end else begin
      irq_req    <= (state_next == REQ);
      irq_sel    <= (state_next == LOAD);
      irq_active <= (state_next == SERVICE);
      if (fire) begin
        irq_bus <= {win_ovf, ID_BASE + IRQ_ID_W'(win.idx)};
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_lines;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        irq_ack;
  logic        irq_eoi;
  logic        irq_req;
  logic        irq_sel;
  logic [16:0] irq_bus;
  logic        irq_active;
  logic [7:0]  pending;

  int checkCount = 0;
  int errorCount = 0;

  irq_ctrl #(
    .N_SRC      (8),
    .ID_BASE    (16'h0010),
    .MASK_RESET (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_lines  (irq_lines),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .irq_req    (irq_req),
    .irq_sel    (irq_sel),
    .irq_bus    (irq_bus),
    .irq_active (irq_active),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] lines, input logic we, input logic [15:0] wdata,
                               input logic ack, input logic eoi);
    irq_lines  = lines;
    mask_we    = we;
    mask_wdata = wdata;
    irq_ack    = ack;
    irq_eoi    = eoi;
  endtask

  task automatic writeMask(input logic [7:0] lines, input logic [15:0] m);
    applyStimulus(lines, 1'b1, m, 1'b0, 1'b0);
    tick();
    applyStimulus(lines, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_req", 32'(irq_req), 32'd0);
    checkOutput("rst_sel", 32'(irq_sel), 32'd0);
    checkOutput("rst_bus", 32'(irq_bus), 32'd0);
    rst = 1'b0;
    tick();

    // Single IRQ on line 3
    writeMask(8'h00, 16'h0008);
    applyStimulus(8'h08, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(2);
    checkOutput("single_pend_early", 32'(pending), 32'h00);
    tick();
    checkOutput("single_pend_k2", 32'(pending), 32'h08);
    checkOutput("single_req_k2", 32'(irq_req), 32'd0);
    tick();
    checkOutput("single_req_k3", 32'(irq_req), 32'd1);
    applyStimulus(8'h08, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("single_sel", 32'(irq_sel), 32'd1);
    checkOutput("single_req_off", 32'(irq_req), 32'd0);
    checkOutput("single_bus", 32'(irq_bus), 32'h00013);
    checkOutput("single_pend_clr", 32'(pending), 32'h00);
    applyStimulus(8'h08, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("single_sel_once", 32'(irq_sel), 32'd0);
    checkOutput("single_active", 32'(irq_active), 32'd1);
    checkOutput("single_bus_hold", 32'(irq_bus), 32'h00013);
    applyStimulus(8'h08, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checkOutput("single_eoi", 32'(irq_active), 32'd0);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(3);

    // Priority chosen at ack time
    writeMask(8'h00, 16'h00FF);
    applyStimulus(8'h60, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(4);
    checkOutput("prio_req", 32'(irq_req), 32'd1);
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(3);
    checkOutput("prio_pend3", 32'(pending), 32'h62);
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("prio_bus1", 32'(irq_bus), 32'h00011);
    checkOutput("prio_pend_after", 32'(pending), 32'h60);
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("prio_rereq", 32'(irq_req), 32'd1);
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("prio_bus5", 32'(irq_bus), 32'h00015);
    checkOutput("prio_pend40", 32'(pending), 32'h40);
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h62, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("prio_bus6", 32'(irq_bus), 32'h00016);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(2);

    // Overflow on line 2 while masked
    writeMask(8'h00, 16'h0000);
    for (int p = 0; p < 2; p++) begin
      applyStimulus(8'h04, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick(3);
      applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      tick(3);
    end
    checkOutput("ovf_pend_masked", 32'(pending), 32'h04);
    checkOutput("ovf_req_masked", 32'(irq_req), 32'd0);
    writeMask(8'h00, 16'h0004);
    tick();
    checkOutput("ovf_req", 32'(irq_req), 32'd1);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_bus", 32'(irq_bus), 32'h10012);
    checkOutput("ovf_pend_clr", 32'(pending), 32'h00);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h04, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(4);
    checkOutput("ovf_again_req", 32'(irq_req), 32'd1);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_cleared_bus", 32'(irq_bus), 32'h00012);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(2);

    // Mask drop coinciding with ack
    applyStimulus(8'h04, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(4);
    checkOutput("drop_req", 32'(irq_req), 32'd1);
    applyStimulus(8'h04, 1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("drop_req_off", 32'(irq_req), 32'd0);
    checkOutput("drop_no_sel", 32'(irq_sel), 32'd0);
    checkOutput("drop_pend", 32'(pending), 32'h04);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("drop_no_sel2", 32'(irq_sel), 32'd0);
    checkOutput("drop_idle", 32'(irq_req), 32'd0);
    checkOutput("drop_no_active", 32'(irq_active), 32'd0);

    // Spurious eoi in IDLE, spurious ack in SERVICE
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checkOutput("spur_eoi_req", 32'(irq_req), 32'd0);
    checkOutput("spur_eoi_sel", 32'(irq_sel), 32'd0);
    checkOutput("spur_eoi_act", 32'(irq_active), 32'd0);
    writeMask(8'h00, 16'h0004);
    tick();
    checkOutput("spur_req", 32'(irq_req), 32'd1);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("spur_load_sel", 32'(irq_sel), 32'd1);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("spur_ack_act", 32'(irq_active), 32'd1);
    checkOutput("spur_ack_sel", 32'(irq_sel), 32'd0);
    checkOutput("spur_ack_req", 32'(irq_req), 32'd0);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset while in SERVICE
    #2;
    rst = 1'b1;
    #2;
    checkOutput("midrst_req", 32'(irq_req), 32'd0);
    checkOutput("midrst_sel", 32'(irq_sel), 32'd0);
    checkOutput("midrst_act", 32'(irq_active), 32'd0);
    checkOutput("midrst_pend", 32'(pending), 32'h00);
    checkOutput("midrst_bus", 32'(irq_bus), 32'h00000);
    tick(2);
    rst = 1'b0;
    applyStimulus(8'h04, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(5);
    checkOutput("midrst_mask_pend", 32'(pending), 32'h04);
    checkOutput("midrst_mask_req", 32'(irq_req), 32'd0);
    applyStimulus(8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the D16i core. It sits directly upstream of the register file's IRQ write port.
- Synchronises external interrupt lines, edge-detects them and latches pending bits.
- Arbitrates by fixed priority and handshakes with the control unit (irq_req/irq_ack).
- On acceptance it drives a one-cycle irq_sel pulse with the interrupt ID on irq_bus. The register file captures that ID into SPR2 on the following negedge.

Parameters:
- N_SRC, 8: number of interrupt sources (1..16).
- ID_BASE, 16'h0010: ID of source 0. Source i has ID ID_BASE+i.
- MASK_RESET, 16'h0000: reset value of the enable mask. Only the low N_SRC bits are used.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- irq_lines  in  N_SRC  asynchronous external interrupt lines, rising-edge sensitive.
- mask_we  in  1  write enable for the mask register.
- mask_wdata  in  16  new mask (from c_bus); bits [N_SRC-1:0] are used.
- irq_ack  in  1  control unit accepts the interrupt (single-cycle pulse).
- irq_eoi  in  1  end-of-interrupt from the control unit (single-cycle pulse).
- irq_req  out  1  interrupt request to the control unit.
- irq_sel  out  1  one-cycle strobe to the regfile IRQ write port.
- irq_bus  out  17  [15:0] ID of the winning source; [16] overflow flag of the winner.
- irq_active  out  1  an interrupt is in service.
- pending  out  N_SRC  current pending bits (status).

Behaviour:
- Reset (async, any cycle, including mid-handshake):
  - state goes to IDLE; pending and overflow clear; synchroniser flops clear.
  - mask becomes MASK_RESET; irq_bus, winner register and output registers clear.
  - irq_req=0, irq_sel=0, irq_active=0.
- Synchroniser:
  - 2-flop synchroniser per line, plus a third flop holding the previous value for edge detection.
  - Rise is detected when sync2=1 and prev=0.
  - A line that rises before posedge k sets its pending bit at posedge k+2.
- Pending and overflow:
  - A detected rise sets pending[i]. This happens regardless of mask.
  - If pending[i] is already 1 when a rise is detected, overflow[i] is set (sticky).
  - If the winner's pending bit is cleared and a new rise on the same source arrives in the same cycle, set wins: pending stays 1 and overflow is not set.
- Mask:
  - When mask_we=1, mask takes mask_wdata at that posedge.
  - Mask gates requests only. It never clears pending bits.
- Enabled set: enabled pending = pending & mask.
- Priority: fixed, lowest index highest. The winner is chosen at ack time, not at request time.
- State machine (registered, one-hot or binary; encoding defined in the package):
  - IDLE -> REQ: when enabled pending is nonzero. irq_req=1 from the next cycle.
  - REQ -> IDLE: when enabled pending becomes zero (mask write). irq_ack in that same cycle is ignored.
  - REQ -> LOAD: when irq_ack=1 and enabled pending is nonzero. At that posedge:
    - winner is latched; irq_bus = {overflow[w], ID_BASE+w}.
    - pending[w] and overflow[w] are cleared.
    - irq_sel=1 and irq_req=0.
  - LOAD -> SERVICE: unconditionally after one cycle. irq_sel returns to 0; irq_bus holds its value; irq_active=1.
  - SERVICE -> IDLE: on irq_eoi=1. irq_active=0. New requests are re-evaluated in IDLE on the next cycle.
- Ignored inputs:
  - irq_ack outside REQ is ignored.
  - irq_eoi outside SERVICE is ignored.
- Nesting: none. Sources pending during SERVICE wait for IDLE.
- Outputs:
  - irq_sel is high for exactly one cycle per accepted interrupt.
  - irq_sel is registered and stable across the negedge on which the regfile writes.
  - Latency from a line's rise (before posedge k) to irq_req is 4 posedges (irq_req high after posedge k+3), provided the line is enabled and state is IDLE.
- Width: the ID add is 16-bit; it wraps modulo 2^16 if ID_BASE+N_SRC-1 exceeds 16'hFFFF.

Decomposition:
- Package d16i_irq_pkg contains:
  - irq_state_t enum {IDLE, REQ, LOAD, SERVICE}.
  - IRQ_ID_W=16.
  - IRQ_BUS_W=17.
  - Function prio_enc(vector) returning the lowest set index and a valid bit.
- Sub-module irq_sync (one per line, generated):
  - 2-flop synchroniser plus prev flop.
  - Output rise pulse.
  - Uses the same clk and async rst.

Test Plan:
- Reset/idle: assert rst mid-SERVICE with irq_lines=8'h00 -> irq_req=0, irq_sel=0, irq_active=0, pending=0, mask=MASK_RESET.
- Single IRQ:
  - Stimulus: mask=8'h08; raise line 3 before posedge k.
  - Expected: pending[3]=1 at k+2; irq_req=1 after k+3.
  - Then: ack at posedge m -> irq_sel=1 for one cycle, irq_bus=17'h00013; after m+1, irq_active=1; eoi -> IDLE.
- Priority at ack:
  - Stimulus: mask=8'hFF; raise lines 5 and 6; raise line 1 while in REQ; then ack.
  - Expected: irq_bus=17'h00011 and pending=8'h60 after LOAD. After eoi, the next ack yields ID 16'h0015.
- Overflow:
  - Stimulus: mask=0; pulse line 2 twice; then set mask=8'h04 and ack.
  - Expected: irq_bus=17'h10012; overflow[2] cleared after LOAD.
- Mask drop:
  - Stimulus: in REQ, write mask=0 in the same cycle as irq_ack.
  - Expected: state IDLE, irq_sel never pulses, pending unchanged.
- Spurious handshake:
  - Stimulus: irq_eoi in IDLE; irq_ack in SERVICE.
  - Expected: no state change, no irq_sel.
